m_cache_refill: RTL

M_CACHE_REFILL -- requirements
Module: m_cache_refill

---
 rtl/m_cache_refill.sv | 113 +++++++++++
 1 files changed

// File: rtl/m_cache_refill.sv
// Cache line refill engine: fetches a 4-word line critical-word-first with wrap,
// forwards the critical word early, and installs the line when no store conflicts.
module m_cache_refill #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_we,
  output logic                  o_busy,
  output logic                  o_mem_req,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_gnt,
  input  logic                  i_mem_rvalid,
  input  logic [31:0]           i_mem_rdata,
  output logic                  o_cw_valid,
  output logic [31:0]           o_cw_data,
  output logic                  o_ie,
  output logic [ADDR_WIDTH-1:0] o_iaddr,
  output logic [127:0]          o_idata,
  output logic                  o_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_INSTALL
  } state_t;

  state_t                    state_q, state_d;
  logic [ADDR_WIDTH-5:0]     line_q, line_d;
  logic [1:0]                ptr_q, ptr_d;
  logic [2:0]                count_q, count_d;
  logic [3:0][31:0]          data_q, data_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      line_q  <= '0;
      ptr_q   <= '0;
      count_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    ptr_d      = ptr_q;
    count_d    = count_q;
    data_d     = data_q;
    o_mem_req  = 1'b0;
    o_cw_valid = 1'b0;
    o_cw_data  = '0;
    o_ie       = 1'b0;
    o_done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_req) begin
          line_d  = i_addr[ADDR_WIDTH-1:4];
          ptr_d   = i_addr[3:2];
          count_d = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        o_mem_req = 1'b1;
        if (i_mem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_mem_rvalid) begin
          data_d[ptr_q] = i_mem_rdata;
          ptr_d         = ptr_q + 2'd1;
          count_d       = count_q + 3'd1;
          // The first returned word is always the one the cache missed on.
          if (count_q == 3'd0) begin
            o_cw_valid = 1'b1;
            o_cw_data  = i_mem_rdata;
          end
          state_d = (count_q == 3'd3) ? S_INSTALL : S_REQ;
        end
      end
      S_INSTALL: begin
        // A store owns the cache array this cycle, so the install waits it out.
        if (!i_we) begin
          o_ie    = 1'b1;
          o_done  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_busy     = (state_q != S_IDLE);
  assign o_mem_addr = {line_q, ptr_q, 2'b00};
  assign o_iaddr    = {line_q, 4'b0000};
  assign o_idata    = data_q;

endmodule
